// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 encodings for the RV32I load/store sizes
//   - FSM state enumeration
//   - helpers: byte-enable generation, store-lane replication, op legality
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_e;

  // Byte enables for a store of the given size (funct3[1:0]) at byte offset addr.
  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr;
      2'b01:   be = 4'b0011 << {addr[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store data across all lanes so the memory picks the enabled ones.
  function automatic logic [31:0] store_repl(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] word;
    case (size)
      2'b00:   word = {4{data[7:0]}};
      2'b01:   word = {2{data[15:0]}};
      default: word = data;
    endcase
    return word;
  endfunction

  // An op is legal when its funct3 exists for its direction and the address
  // is naturally aligned for the access size.
  function automatic logic op_legal(input logic is_load, input logic [2:0] f3,
                                    input logic [1:0] addr);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr[0];
      F3_W:    ok = (addr == 2'b00);
      F3_BU:   ok = is_load;
      F3_HU:   ok = is_load & ~addr[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit (req/gnt/rvalid protocol).
//   master: the load/store unit (drives request, address, enables, write data)
//   slave : the data memory (drives gnt, rvalid, read data)
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Combinational load-data alignment.
//   rdata  : raw word from memory
//   offset : byte offset of the access within the word
//   funct3 : size/sign selector
//   data   : word shifted down to lane 0 and sign/zero extended
module load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted_s;

  // Bring the addressed byte/half down to bit 0.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
  end

  // Extend according to size and signedness.
  always_comb begin
    data = {DATA_W{1'b0}};
    case (funct3)
      F3_B:    data = {{(DATA_W-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    data = {{(DATA_W-16){shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    data = shifted_s;
      F3_BU:   data = {{(DATA_W-8){1'b0}}, shifted_s[7:0]};
      F3_HU:   data = {{(DATA_W-16){1'b0}}, shifted_s[15:0]};
      default: data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit.
// Takes the ALU result as effective address, checks the op, runs one
// req/gnt/rvalid transaction on the data-memory port while stalling the
// pipeline, and returns aligned, extended load data one cycle after rvalid.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   load_i, store_i  : EX/MEM holds a load / store (both set -> load)
//   funct3_i         : size/sign selector
//   addr_i, wdata_i  : effective address, store data (rs2)
//   rd_i             : load destination register
//   mem              : data-memory port (master side)
//   stall_o          : freeze IF..EX/MEM this cycle
//   wb_valid_o       : registered pulse, load data ready (with wb_rd_o, wb_data_o)
//   fault_o          : registered pulse, misaligned access or illegal funct3
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               store_i,
  input  logic [2:0]         funct3_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [4:0]         rd_i,
  load_store_unit_if.master  mem,
  output logic               stall_o,
  output logic               wb_valid_o,
  output logic [4:0]         wb_rd_o,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic               fault_o
);

  lsu_state_e        state_r;
  lsu_state_e        state_nx_s;

  logic              op_s;
  logic              is_load_s;
  logic              legal_s;
  logic              stall_s;
  logic              accept_s;
  logic              fault_s;
  logic              capture_s;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        be_r;
  logic              we_r;
  logic [2:0]        f3_r;
  logic [4:0]        rd_r;

  logic [DATA_W-1:0] aligned_s;
  logic              wb_valid_r;
  logic [4:0]        wb_rd_r;
  logic [DATA_W-1:0] wb_data_r;
  logic              fault_r;

  // Decode the incoming op; a simultaneous load and store counts as a load.
  always_comb begin
    op_s      = load_i | store_i;
    is_load_s = load_i;
    legal_s   = op_legal(is_load_s, funct3_i, addr_i[1:0]);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-cycle control. The op is only looked at in IDLE, so a
  // frozen pipeline holding the same op cannot issue it twice.
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    accept_s   = 1'b0;
    fault_s    = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_s) begin
          if (legal_s) begin
            stall_s    = 1'b1;
            accept_s   = 1'b1;
            state_nx_s = ST_REQ;
          end else begin
            fault_s    = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // rvalid here is a protocol violation and is deliberately ignored.
        if (mem.mem_gnt) begin
          if (we_r) begin
            state_nx_s = ST_IDLE;
          end else begin
            stall_s    = 1'b1;
            state_nx_s = ST_WAIT;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          capture_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Request latch: everything the memory port needs is frozen at acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= 4'b0000;
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      rd_r    <= 5'd0;
    end else if (accept_s) begin
      addr_r  <= addr_i;
      wdata_r <= store_repl(funct3_i[1:0], wdata_i);
      be_r    <= be_for(funct3_i[1:0], addr_i[1:0]);
      we_r    <= ~is_load_s;
      f3_r    <= funct3_i;
      rd_r    <= rd_i;
    end
  end

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata  (mem.mem_rdata),
    .offset (addr_r[1:0]),
    .funct3 (f3_r),
    .data   (aligned_s)
  );

  // Write-back and fault pulses, one cycle after the event that causes them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= {DATA_W{1'b0}};
      fault_r    <= 1'b0;
    end else begin
      wb_valid_r <= capture_s;
      fault_r    <= fault_s;
      if (capture_s) begin
        wb_rd_r   <= rd_r;
        wb_data_r <= aligned_s;
      end
    end
  end

  // Memory port is driven straight from state and latched registers.
  always_comb begin
    mem.mem_req   = (state_r == ST_REQ);
    mem.mem_we    = we_r;
    mem.mem_addr  = {addr_r[ADDR_W-1:2], 2'b00};
    mem.mem_be    = be_r;
    mem.mem_wdata = wdata_r;
  end

  // Pipeline-facing outputs; stall is forced low while reset is held so the
  // pipeline is never frozen by an op sitting on the inputs during reset.
  always_comb begin
    stall_o    = stall_s & ~rst_i;
    wb_valid_o = wb_valid_r;
    wb_rd_o    = wb_rd_r;
    wb_data_o  = wb_data_r;
    fault_o    = fault_r;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// ops against a byte-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        load_i;
  logic        store_i;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load_i),
    .store_i    (store_i),
    .funct3_i   (funct3),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rd_i       (rd),
    .mem        (bus.master),
    .stall_o    (stall),
    .wb_valid_o (wb_valid),
    .wb_rd_o    (wb_rd),
    .wb_data_o  (wb_data),
    .fault_o    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int op_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_legal(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
    int n = op_bytes(f3);
    if (n == 0) return 1'b0;
    if (!is_load && f3[2]) return 1'b0;
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be = 4'b0000;
    int off = int'(a % 4);
    int n = op_bytes(f3);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w = 32'h0;
    int n = op_bytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] v = 32'h0;
    int off = int'(a % 4);
    int n = op_bytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- one complete op, checked cycle by cycle ----------------
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] r, input logic [31:0] rword,
                        input int gnt_dly, input int rv_dly);
    bit is_load = ld;
    bit ok = model_legal(is_load, f3, a);
    @(negedge clk);
    load_i = ld; store_i = st; funct3 = f3; addr = a; wdata = wd; rd = r;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    #1;
    check_eq("acc_stall", 32'(stall), 32'(ok));
    check_eq("acc_req", 32'(bus.mem_req), 32'd0);
    check_eq("acc_wbv", 32'(wb_valid), 32'd0);
    if (!ok) begin
      @(negedge clk);
      load_i = 1'b0; store_i = 1'b0;
      #1;
      check_eq("flt_pulse", 32'(fault), 32'd1);
      check_eq("flt_req", 32'(bus.mem_req), 32'd0);
      check_eq("flt_wbv", 32'(wb_valid), 32'd0);
      @(negedge clk); #1;
      check_eq("flt_clr", 32'(fault), 32'd0);
      check_eq("flt_req2", 32'(bus.mem_req), 32'd0);
    end else begin
      for (int k = 0; k <= gnt_dly; k++) begin
        @(negedge clk);
        bus.mem_gnt = (k == gnt_dly);
        // operands on the pipeline side may change; the request must not
        addr = $urandom; wdata = $urandom; rd = 5'($urandom);
        #1;
        check_eq("req_req", 32'(bus.mem_req), 32'd1);
        check_eq("req_addr", bus.mem_addr, {a[31:2], 2'b00});
        check_eq("req_we", 32'(bus.mem_we), 32'(!is_load));
        if (!is_load) begin
          check_eq("req_be", 32'(bus.mem_be), 32'(model_be(f3, a)));
          check_eq("req_wdata", bus.mem_wdata, model_wdata(f3, wd));
        end
        check_eq("req_stall", 32'(stall), 32'(is_load || (k != gnt_dly)));
        check_eq("req_fault", 32'(fault), 32'd0);
      end
      if (is_load) begin
        for (int j = 0; j <= rv_dly; j++) begin
          @(negedge clk);
          bus.mem_gnt = 1'b0;
          bus.mem_rvalid = (j == rv_dly);
          bus.mem_rdata = (j == rv_dly) ? rword : $urandom;
          #1;
          check_eq("wait_req", 32'(bus.mem_req), 32'd0);
          check_eq("wait_stall", 32'(stall), 32'(j != rv_dly));
          check_eq("wait_wbv", 32'(wb_valid), 32'd0);
        end
      end
      @(negedge clk);
      load_i = 1'b0; store_i = 1'b0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      #1;
      check_eq("done_wbv", 32'(wb_valid), 32'(is_load));
      if (is_load) begin
        check_eq("done_wbdata", wb_data, model_load(f3, a, rword));
        check_eq("done_wbrd", 32'(wb_rd), 32'(r));
      end
      check_eq("done_req", 32'(bus.mem_req), 32'd0);
      check_eq("done_stall", 32'(stall), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_stall"}, 32'(stall), 32'd0);
    check_eq({pfx, "_req"}, 32'(bus.mem_req), 32'd0);
    check_eq({pfx, "_we"}, 32'(bus.mem_we), 32'd0);
    check_eq({pfx, "_addr"}, bus.mem_addr, 32'd0);
    check_eq({pfx, "_be"}, 32'(bus.mem_be), 32'd0);
    check_eq({pfx, "_wdata"}, bus.mem_wdata, 32'd0);
    check_eq({pfx, "_wbv"}, 32'(wb_valid), 32'd0);
    check_eq({pfx, "_wbrd"}, 32'(wb_rd), 32'd0);
    check_eq({pfx, "_wbdata"}, wb_data, 32'd0);
    check_eq({pfx, "_fault"}, 32'(fault), 32'd0);
  endtask

  logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    rst = 1'b1; load_i = 1'b0; store_i = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; rd = 5'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 0, 0);        // SW
    run_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 32'h0, 0, 0);        // SB lane 3
    run_op(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 5'd3, 32'h0080FF00, 0, 0);        // LB
    run_op(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 5'd4, 32'h0080FF00, 0, 0);        // LBU
    run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd9, 32'h80011234, 3, 2);        // LH slow mem
    run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd1, 32'h0, 0, 0);               // LW misaligned
    run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 5'd0, 32'h0, 0, 0);               // store BU illegal
    run_op(1'b1, 1'b1, 3'b101, 32'h202, 32'h0, 5'd17, 32'h9ABC5678, 1, 1);       // load+store -> LHU
    run_op(1'b0, 1'b1, 3'b001, 32'h302, 32'h0000CAFE, 5'd0, 32'h0, 2, 0);        // SH upper half

    // reset while waiting for read data
    @(negedge clk);
    load_i = 1'b1; funct3 = 3'b010; addr = 32'h200; rd = 5'd7;
    @(negedge clk); bus.mem_gnt = 1'b1;
    @(negedge clk); bus.mem_gnt = 1'b0;
    #1;
    check_eq("rstw_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rstw");
    @(negedge clk);
    rst = 1'b0; load_i = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678; bus.mem_gnt = 1'b1;
    #1;
    check_eq("late_stall", 32'(stall), 32'd0);
    check_eq("late_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
    #1;
    check_eq("late_wbv", 32'(wb_valid), 32'd0);
    check_eq("late_fault", 32'(fault), 32'd0);
    check_eq("late_req2", 32'(bus.mem_req), 32'd0);

    // randomized ops
    for (int t = 0; t < 200; t++) begin
      int sel = $urandom_range(0, 3);
      bit ld = (sel != 1);
      bit st = (sel == 1) || (sel == 2);
      logic [2:0] f3;
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = legal_f3[$urandom_range(0, 2)];
      run_op(ld, st, f3, $urandom, $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
